// File: rtl/conv1_input_feeder.sv
// rtl/conv1_input_feeder.sv - kernel-then-pixel sequencer feeding convolution_layer1
// Define FEEDER_KTIMEOUT_EN to bound the kernel-done wait by TIMEOUT cycles.
module conv1_input_feeder #(
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int CHANEL     = 3,
    parameter int NUM_KERNEL = 4,
    parameter int KSIZE      = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        k_valid,
    input  logic [31:0] k_data,
    output logic        k_ready,
    input  logic        p_valid,
    input  logic [31:0] p_data0,
    input  logic [31:0] p_data1,
    input  logic [31:0] p_data2,
    output logic        p_ready,
    output logic        load_kernel,
    output logic [31:0] kernel,
    output logic        valid_in,
    output logic [31:0] data_in0,
    output logic [31:0] data_in1,
    output logic [31:0] data_in2,
    input  logic        load_kernel_done,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int KWORDS = NUM_KERNEL * CHANEL * KSIZE * KSIZE;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int KCNT_W = $clog2(KWORDS + 1);
    localparam int PCNT_W = $clog2(NPIX + 1);

    typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, STREAM, DONE} state_t;

    state_t              state;
    logic [KCNT_W-1:0]   kcnt;
    logic [PCNT_W-1:0]   pcnt;

`ifdef FEEDER_KTIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    logic [WCNT_W-1:0]   wcnt;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT == 0);
    assign err        = 1'b0;
`endif

    // Ready and status come straight from the state register, never from valids.
    assign k_ready = (state == KLOAD);
    assign p_ready = (state == STREAM);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (resetn) begin
            state       <= IDLE;
            kcnt        <= '0;
            pcnt        <= '0;
            load_kernel <= 1'b0;
            kernel      <= '0;
            valid_in    <= 1'b0;
            data_in0    <= '0;
            data_in1    <= '0;
            data_in2    <= '0;
`ifdef FEEDER_KTIMEOUT_EN
            wcnt        <= '0;
            err         <= 1'b0;
`endif
        end else begin
            load_kernel <= 1'b0;
            valid_in    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= KLOAD;
                        kcnt  <= '0;
`ifdef FEEDER_KTIMEOUT_EN
                        err   <= 1'b0;
`endif
                    end
                end
                KLOAD: begin
                    if (k_valid) begin
                        kernel      <= k_data;
                        load_kernel <= 1'b1;
                        kcnt        <= kcnt + 1'b1;
                        if (kcnt == KCNT_W'(KWORDS - 1)) begin
                            state <= KWAIT;
`ifdef FEEDER_KTIMEOUT_EN
                            wcnt  <= '0;
`endif
                        end
                    end
                end
                KWAIT: begin
                    if (load_kernel_done) begin
                        state <= STREAM;
                        pcnt  <= '0;
                    end
`ifdef FEEDER_KTIMEOUT_EN
                    else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
`endif
                end
                STREAM: begin
                    if (p_valid) begin
                        data_in0 <= p_data0;
                        data_in1 <= p_data1;
                        data_in2 <= p_data2;
                        valid_in <= 1'b1;
                        pcnt     <= pcnt + 1'b1;
                        if (pcnt == PCNT_W'(NPIX - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_input_feeder.sv
// tb/tb_conv1_input_feeder.sv - randomized self-checking bench for conv1_input_feeder
// Timeout scenario is exercised when FEEDER_KTIMEOUT_EN is defined.
module tb_conv1_input_feeder;

    localparam int KW  = 108;
    localparam int NP  = 1024;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        k_valid = 1'b0;
    logic [31:0] k_data = '0;
    logic        k_ready;
    logic        p_valid = 1'b0;
    logic [31:0] p_data0 = '0, p_data1 = '0, p_data2 = '0;
    logic        p_ready;
    logic        load_kernel;
    logic [31:0] kernel;
    logic        valid_in;
    logic [31:0] data_in0, data_in1, data_in2;
    logic        load_kernel_done = 1'b0;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    // Reference model: last word delivered to the layer on each port.
    logic [31:0] m_kernel = '0;
    logic [31:0] m_d0 = '0, m_d1 = '0, m_d2 = '0;

    int r_kerr, r_perr, r_ctl, r_rst, r_nlk, r_nvi, r_ndone;
    bit r_hung;

    conv1_input_feeder #(
        .WIDTH(32), .HEIGHT(32), .CHANEL(3), .NUM_KERNEL(4), .KSIZE(3), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
        .p_valid(p_valid), .p_data0(p_data0), .p_data1(p_data1), .p_data2(p_data2),
        .p_ready(p_ready),
        .load_kernel(load_kernel), .kernel(kernel),
        .valid_in(valid_in), .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
        .load_kernel_done(load_kernel_done),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_results();
        r_kerr = 0; r_perr = 0; r_ctl = 0; r_rst = 0;
        r_nlk = 0; r_nvi = 0; r_ndone = 0; r_hung = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        m_kernel = '0; m_d0 = '0; m_d1 = '0; m_d2 = '0;
    endtask

    // Offers KW kernel words; each accepted word must appear on the layer port one cycle later.
    task automatic feed_kernels(input int kgap, input bit kseq, input bit hold_kdone);
        logic prev_hs;
        int kn;
        int guard;
        prev_hs = 1'b0; kn = 0; guard = 0;
        load_kernel_done = hold_kdone;
        while (kn < KW && guard < 20000) begin
            if (k_ready !== 1'b1 || p_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) r_ctl++;
            if (load_kernel !== prev_hs || kernel !== m_kernel) r_kerr++;
            if (load_kernel === 1'b1) r_nlk++;
            k_valid = ($urandom_range(99) >= kgap);
            k_data  = kseq ? 32'(kn) : $urandom;
            tick();
            prev_hs = k_valid;
            if (k_valid) begin
                m_kernel = k_data;
                kn++;
            end
            guard++;
        end
        k_valid = 1'b0;
        if (guard >= 20000) r_hung = 1'b1;
    endtask

    // pmode: 0 back-to-back, 1 toggling 1/0, 2 random gaps.
    task automatic run_image(input int kgap, input bit kseq, input bit kdone_early,
                             input int kdone_delay, input int pmode, input bit start_noise,
                             input int reset_at);
        logic prev_hs;
        logic pv;
        logic tog;
        int pn;
        int guard;
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_kernels(kgap, kseq, kdone_early);
        for (int d = 0; d <= kdone_delay; d++) begin
            load_kernel_done = kdone_early || (d == kdone_delay);
            if (k_ready !== 1'b0 || p_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) r_ctl++;
            if (load_kernel !== 1'(d == 0) || kernel !== m_kernel) r_kerr++;
            if (load_kernel === 1'b1) r_nlk++;
            tick();
        end
        load_kernel_done = 1'b0;
        prev_hs = 1'b0; tog = 1'b1; pn = 0; guard = 0;
        while (pn < NP && guard < 20000) begin
            if (p_ready !== 1'b1 || k_ready !== 1'b0 || busy !== 1'b1 || load_kernel !== 1'b0) r_ctl++;
            if (done === 1'b1) r_ndone++;
            if (valid_in !== prev_hs || {data_in0, data_in1, data_in2} !== {m_d0, m_d1, m_d2}) r_perr++;
            if (valid_in === 1'b1) r_nvi++;
            if (pn == reset_at) begin
                resetn = 1'b1;
                p_valid = 1'b0;
                start = 1'b0;
                tick();
                resetn = 1'b0;
                m_kernel = '0; m_d0 = '0; m_d1 = '0; m_d2 = '0;
                if ({k_ready, p_ready, load_kernel, valid_in, busy, done, err} !== 7'b0) r_rst++;
                if ({kernel, data_in0, data_in1, data_in2} !== 128'b0) r_rst++;
                for (int i = 0; i < 4; i++) begin
                    if (done === 1'b1) r_ndone++;
                    if (busy !== 1'b0 || valid_in !== 1'b0 || p_ready !== 1'b0) r_rst++;
                    tick();
                end
                return;
            end
            case (pmode)
                0:       pv = 1'b1;
                1:       begin pv = tog; tog = ~tog; end
                default: pv = ($urandom_range(99) < 70);
            endcase
            p_valid = pv;
            p_data0 = $urandom; p_data1 = $urandom; p_data2 = $urandom;
            start   = start_noise && ($urandom_range(9) == 0);
            tick();
            prev_hs = pv;
            if (pv) begin
                m_d0 = p_data0; m_d1 = p_data1; m_d2 = p_data2;
                pn++;
            end
            guard++;
        end
        if (guard >= 20000) r_hung = 1'b1;
        p_valid = 1'b0;
        start = 1'b0;
        if (valid_in !== prev_hs || {data_in0, data_in1, data_in2} !== {m_d0, m_d1, m_d2}) r_perr++;
        if (valid_in === 1'b1) r_nvi++;
        if (done === 1'b1) r_ndone++;
        if (busy !== 1'b1 || p_ready !== 1'b0 || k_ready !== 1'b0) r_ctl++;
        start = start_noise;
        tick();
        start = 1'b0;
        if (done === 1'b1) r_ndone++;
        if (busy !== 1'b0 || valid_in !== 1'b0 || p_ready !== 1'b0 || k_ready !== 1'b0) r_ctl++;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (3) tick();
        total++; if ({k_ready, p_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {k_ready, p_ready}); end
        total++; if ({load_kernel, valid_in} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {load_kernel, valid_in}); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {busy, done, err}); end
        total++; if (kernel !== 32'h0) begin bad++; $display("FAIL reset_kernel: got %h want 0", kernel); end
        total++; if ({data_in0, data_in1, data_in2} !== 96'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {data_in0, data_in1, data_in2}); end
        resetn = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_kernel_back_to_back();
        run_image(0, 1'b1, 1'b0, 5, 0, 1'b0, -1);
        total++; if (r_kerr !== 0) begin bad++; $display("FAIL kb2b_kernel: bad cycles=%0d want 0", r_kerr); end
        total++; if (r_nlk !== KW) begin bad++; $display("FAIL kb2b_lk_count: got %0d want %0d", r_nlk, KW); end
        total++; if (r_ctl !== 0 || r_hung) begin bad++; $display("FAIL kb2b_ctl: bad cycles=%0d hung=%0d want 0", r_ctl, r_hung); end
        total++; if (r_perr !== 0 || r_nvi !== NP) begin bad++; $display("FAIL kb2b_pixels: bad=%0d pulses=%0d want 0/%0d", r_perr, r_nvi, NP); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL kb2b_done: pulses=%0d want 1", r_ndone); end
    endtask

    task automatic test_pixel_toggle();
        run_image(20, 1'b0, 1'b0, 5, 1, 1'b0, -1);
        total++; if (r_kerr !== 0 || r_nlk !== KW) begin bad++; $display("FAIL toggle_kernel: bad=%0d strobes=%0d want 0/%0d", r_kerr, r_nlk, KW); end
        total++; if (r_perr !== 0) begin bad++; $display("FAIL toggle_pixel_data: bad cycles=%0d want 0", r_perr); end
        total++; if (r_nvi !== NP) begin bad++; $display("FAIL toggle_valid_count: got %0d want %0d", r_nvi, NP); end
        total++; if (r_ctl !== 0 || r_hung) begin bad++; $display("FAIL toggle_ctl: bad cycles=%0d hung=%0d want 0", r_ctl, r_hung); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL toggle_done: pulses=%0d want 1", r_ndone); end
    endtask

    task automatic test_kdone_early();
        run_image(30, 1'b0, 1'b1, 0, 2, 1'b0, -1);
        total++; if (r_ctl !== 0 || r_hung) begin bad++; $display("FAIL early_kdone_ctl: bad cycles=%0d hung=%0d want 0", r_ctl, r_hung); end
        total++; if (r_kerr !== 0 || r_nlk !== KW) begin bad++; $display("FAIL early_kdone_kernel: bad=%0d strobes=%0d want 0/%0d", r_kerr, r_nlk, KW); end
        total++; if (r_perr !== 0 || r_nvi !== NP || r_ndone !== 1) begin bad++; $display("FAIL early_kdone_pixels: bad=%0d pulses=%0d done=%0d want 0/%0d/1", r_perr, r_nvi, r_ndone, NP); end
    endtask

    task automatic test_start_ignored();
        run_image(10, 1'b0, 1'b0, 2, 2, 1'b1, -1);
        total++; if (r_ctl !== 0 || r_hung) begin bad++; $display("FAIL start_noise_ctl: bad cycles=%0d hung=%0d want 0", r_ctl, r_hung); end
        total++; if (r_perr !== 0 || r_nvi !== NP) begin bad++; $display("FAIL start_noise_pixels: bad=%0d pulses=%0d want 0/%0d", r_perr, r_nvi, NP); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL start_noise_done: pulses=%0d want 1", r_ndone); end
    endtask

    task automatic test_reset_midstream();
        run_image(0, 1'b0, 1'b0, 3, 1, 1'b0, 500);
        total++; if (r_rst !== 0) begin bad++; $display("FAIL midreset_outputs: bad cycles=%0d want 0", r_rst); end
        total++; if (r_nvi !== 500 || r_perr !== 0) begin bad++; $display("FAIL midreset_pixels: pulses=%0d bad=%0d want 500/0", r_nvi, r_perr); end
        total++; if (r_ndone !== 0) begin bad++; $display("FAIL midreset_no_done: pulses=%0d want 0", r_ndone); end
        run_image(15, 1'b0, 1'b0, 1, 0, 1'b0, -1);
        total++; if (r_kerr !== 0 || r_nlk !== KW) begin bad++; $display("FAIL postreset_kernel: bad=%0d strobes=%0d want 0/%0d", r_kerr, r_nlk, KW); end
        total++; if (r_perr !== 0 || r_nvi !== NP) begin bad++; $display("FAIL postreset_pixels: bad=%0d pulses=%0d want 0/%0d", r_perr, r_nvi, NP); end
        total++; if (r_ctl !== 0 || r_hung || r_ndone !== 1) begin bad++; $display("FAIL postreset_ctl: bad=%0d hung=%0d done=%0d want 0/0/1", r_ctl, r_hung, r_ndone); end
    endtask

`ifdef FEEDER_KTIMEOUT_EN
    task automatic test_kwait_timeout();
        int n;
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_kernels(0, 1'b0, 1'b0);
        load_kernel_done = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (p_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) r_ctl++;
            tick();
            n++;
        end
        total++; if (n !== TMO) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TMO); end
        total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_err: err=%b busy=%b want 1/0", err, busy); end
        total++; if (r_ctl !== 0 || r_kerr !== 0) begin bad++; $display("FAIL timeout_wait: ctl=%0d kern=%0d want 0/0", r_ctl, r_kerr); end
        repeat (2) tick();
        total++; if (err !== 1'b1 || p_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL timeout_sticky: err=%b p_ready=%b done=%b want 1/0/0", err, p_ready, done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL timeout_clear: err=%b busy=%b want 0/1", err, busy); end
        apply_reset();
    endtask
`else
    task automatic test_err_tied();
        clear_results();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_kernels(0, 1'b0, 1'b0);
        load_kernel_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1 || err !== 1'b0 || p_ready !== 1'b0 || done !== 1'b0) r_ctl++;
            tick();
        end
        total++; if (r_ctl !== 0 || r_kerr !== 0) begin bad++; $display("FAIL kwait_forever: ctl=%0d kern=%0d want 0/0", r_ctl, r_kerr); end
        load_kernel_done = 1'b1;
        tick();
        load_kernel_done = 1'b0;
        total++; if (p_ready !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL kwait_release: p_ready=%b err=%b want 1/0", p_ready, err); end
        apply_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_kernel_back_to_back();
        test_pixel_toggle();
        test_kdone_early();
        test_start_ignored();
        test_reset_midstream();
`ifdef FEEDER_KTIMEOUT_EN
        test_kwait_timeout();
`else
        test_err_tied();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv1_input_feeder.md
# conv1_input_feeder

Sequencer that drives the input side of the first convolution layer: accepts kernel words and 3-channel pixel words from two upstream valid/ready streams, presents them to the layer's kernel-load port (`load_kernel`/`kernel`) and pixel port (`valid_in`/`data_in0..2`), and enforces the kernel-then-image ordering the layer requires. It sits between the image/weight source (DMA or testbench memory) and `convolution_layer1`, and reports per-image busy/done/error status to the top-level controller.

## Interface
- `WIDTH`, 32, image width in pixels
- `HEIGHT`, 32, image height in pixels
- `CHANEL`, 3, input channels (fixed at 3 by the port list)
- `NUM_KERNEL`, 4, number of filters
- `KSIZE`, 3, kernel side; kernel word count KWORDS = NUM_KERNEL*CHANEL*KSIZE*KSIZE (108 default)
- `TIMEOUT`, 1024, kernel-done wait limit in cycles (used only with `FEEDER_KTIMEOUT_EN`)

- `clk` in 1, sole clock, rising edge
- `resetn` in 1, synchronous, active-high reset (port name kept for codebase consistency; asserted = 1)
- `start` in 1, begin one image transaction (pulse; accepted only in IDLE)
- `k_valid` in 1, kernel word valid
- `k_data` in 32, kernel word
- `k_ready` out 1, kernel word accepted when `k_valid & k_ready`
- `p_valid` in 1, pixel valid
- `p_data0`/`p_data1`/`p_data2` in 32 each, channel 0/1/2 pixel
- `p_ready` out 1, pixel accepted when `p_valid & p_ready`
- `load_kernel` out 1, kernel word strobe to layer
- `kernel` out 32, kernel word to layer
- `valid_in` out 1, pixel strobe to layer
- `data_in0`/`data_in1`/`data_in2` out 32 each, pixel channels to layer
- `load_kernel_done` in 1, layer finished storing kernels
- `busy` out 1, high in any state except IDLE
- `done` out 1, one-cycle pulse at end of image
- `err` out 1, sticky kernel-timeout flag, cleared by next accepted `start`

## Operation
- States: IDLE, KLOAD, KWAIT, STREAM, DONE.
- IDLE: `k_ready`=`p_ready`=0. `start`=1 -> KLOAD, `kcnt`<=0, `err`<=0.
- KLOAD: `k_ready`=1. Each handshake: `kernel`<=`k_data`, `load_kernel`<=1 next cycle, `kcnt`++. Cycle without handshake: `load_kernel`<=0, `kernel` holds. Handshake with `kcnt`==KWORDS-1 -> KWAIT. `load_kernel_done` ignored in KLOAD.
- KWAIT: `k_ready`=0. `load_kernel_done`=1 sampled -> STREAM, `pcnt`<=0.
- STREAM: `p_ready`=1. Each handshake: `data_in0..2`<=`p_data0..2`, `valid_in`<=1 next cycle, `pcnt`++. Gaps in `p_valid` produce gaps in `valid_in`; data holds. Handshake with `pcnt`==WIDTH*HEIGHT-1 -> DONE.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `start` outside IDLE ignored. Counters: `kcnt` $clog2(KWORDS+1) bits, `pcnt` $clog2(WIDTH*HEIGHT+1) bits; no wrap within a transaction.
- `resetn` at any cycle, including mid-KLOAD/STREAM: state IDLE, counters 0, partial transaction discarded, no `done`.

## Timing
- Reset values: `k_ready`,`p_ready`,`load_kernel`,`valid_in`,`busy`,`done`,`err` = 0; `kernel`,`data_in0..2` = 0.
- Latency: upstream handshake at cycle t -> layer strobe and data at t+1 (single register stage); throughput one word per cycle.
- `k_ready`/`p_ready` are decoded from registered state only (no combinational path from `k_valid`/`p_valid`).
- Last kernel handshake at t: KWAIT from t+1; `load_kernel_done` high at t+1 -> STREAM at t+2, first `p_ready` at t+2.
- Last pixel handshake at t: `valid_in` at t+1, `done` at t+1, `busy` low at t+2, new `start` accepted at t+2.

## Configuration
- `FEEDER_KTIMEOUT_EN` defined: KWAIT counts cycles; reaching TIMEOUT without `load_kernel_done` sets `err`=1 and goes to IDLE (no STREAM, no `done`).
- Not defined: no counter; KWAIT waits indefinitely; `err` tied 0.

## Test plan
- Reset, `start`, 108 back-to-back kernel words 0..107 -> `load_kernel` high 108 consecutive cycles, `kernel` 0..107 each one cycle after its handshake; `k_ready` drops after word 107.
- Kernel phase done, `load_kernel_done` after 5 cycles, 1024 pixels with `p_valid` toggling 1/0 -> 1024 `valid_in` pulses matching data order, `done` pulse one cycle after last, `busy` low next cycle.
- `load_kernel_done` held high during KLOAD -> no early STREAM; `p_ready` stays 0 until all 108 words accepted.
- `start` pulsed during STREAM and in DONE -> ignored; pixel count and single `done` unchanged.
- `resetn` asserted at pixel 500 -> all outputs 0 next cycle, no `done`; fresh `start` runs a full image normally.
- With `FEEDER_KTIMEOUT_EN`, TIMEOUT=16, `load_kernel_done` never asserted -> `err`=1 after 16 KWAIT cycles, `busy` 0, no `p_ready`; next `start` clears `err`.
